// File: rtl/tl_host_arbiter_pkg.sv
// Shared TileLink definitions for the host arbiter slice.
// Contents: A/D opcode enums, the a_size/beat-counter widths, and tl_num_beats(), which
// returns the number of data beats a single A-channel message occupies.
package tl_host_arbiter_pkg;

  localparam int unsigned SizeWidth    = 4;
  localparam int unsigned BeatCntWidth = 16;

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    ArithmeticData = 3'h2,
    LogicalData    = 3'h3,
    Get            = 3'h4,
    Intent         = 3'h5
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1,
    HintAck       = 3'h2
  } tl_d_op_e;

  // Only opcodes that carry data on A span several beats.
  function automatic int unsigned tl_num_beats(input tl_a_op_e opcode,
                                               input logic [SizeWidth-1:0] size,
                                               input int unsigned data_width);
    int unsigned bytes;
    int unsigned bus_bytes;
    int unsigned beats;
    bytes     = 32'd1 << size;
    bus_bytes = data_width / 8;
    beats     = 1;
    if ((opcode inside {PutFullData, PutPartialData, ArithmeticData, LogicalData}) &&
        (bytes > bus_bytes)) begin
      beats = bytes / bus_bytes;
    end
    return beats;
  endfunction

endpackage

// File: rtl/tl_host_arbiter_if.sv
// TL-UH link bundle (A and D channels plus B/C/E valid/ready for tie-offs).
// Modports: master = the side issuing A requests (a host), slave = the side answering on D.
interface tl_host_arbiter_if import tl_host_arbiter_pkg::*; #(
  parameter int unsigned DataWidth   = 64,
  parameter int unsigned AddrWidth   = 56,
  parameter int unsigned SourceWidth = 4,
  parameter int unsigned SinkWidth   = 1
) ();
  logic                   a_valid;
  logic                   a_ready;
  logic [2:0]             a_opcode;
  logic [2:0]             a_param;
  logic [SizeWidth-1:0]   a_size;
  logic [SourceWidth-1:0] a_source;
  logic [AddrWidth-1:0]   a_address;
  logic [DataWidth/8-1:0] a_mask;
  logic [DataWidth-1:0]   a_data;
  logic                   a_corrupt;

  logic                   d_valid;
  logic                   d_ready;
  logic [2:0]             d_opcode;
  logic [1:0]             d_param;
  logic [SizeWidth-1:0]   d_size;
  logic [SourceWidth-1:0] d_source;
  logic [SinkWidth-1:0]   d_sink;
  logic                   d_denied;
  logic [DataWidth-1:0]   d_data;
  logic                   d_corrupt;

  logic b_valid, b_ready, c_valid, c_ready, e_valid, e_ready;

  modport master (
    output a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    input  a_ready,
    input  d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    output d_ready,
    input  b_valid, c_ready, e_ready,
    output b_ready, c_valid, e_valid
  );

  modport slave (
    input  a_valid, a_opcode, a_param, a_size, a_source, a_address, a_mask, a_data, a_corrupt,
    output a_ready,
    output d_valid, d_opcode, d_param, d_size, d_source, d_sink, d_denied, d_data, d_corrupt,
    input  d_ready,
    output b_valid, c_ready, e_ready,
    input  b_ready, c_valid, e_valid
  );
endinterface

// File: rtl/tl_host_arbiter_rr_picker.sv
// Combinational round-robin picker: grants the first set bit of req at or after prio,
// wrapping around. Ports: req (request vector), prio (start index), gnt (one-hot),
// idx (binary index of gnt), valid (any request).
module tl_host_arbiter_rr_picker #(
  parameter int unsigned  NumReq   = 2,
  localparam int unsigned IdxWidth = $clog2(NumReq)
) (
  input  logic [NumReq-1:0]   req,
  input  logic [IdxWidth-1:0] prio,
  output logic [NumReq-1:0]   gnt,
  output logic [IdxWidth-1:0] idx,
  output logic                valid
);
  always_comb begin : p_pick
    int unsigned j;
    j     = 0;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    for (int unsigned k = 0; k < NumReq; k++) begin
      j = (32'(prio) + k) % NumReq;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        gnt[j] = 1'b1;
        idx    = IdxWidth'(j);
      end
    end
  end
endmodule

// File: rtl/tl_host_arbiter.sv
// Shares one TL-UH device port between NumHosts hosts with zero added latency.
// A: round-robin, locked for a whole message (HOLD while stalled, BURST across beats);
//    device a_source = {host index, host a_source}.
// D: routed back by the top IdxWidth bits of d_source; out-of-range beats are dropped.
// Ports: clk_i, rst_ni (synchronous, active low), host[NumHosts] (slave side of each
// host link), device (master side of the shared downstream link).
module tl_host_arbiter import tl_host_arbiter_pkg::*; #(
  parameter int unsigned  NumHosts        = 2,
  parameter int unsigned  DataWidth       = 64,
  parameter int unsigned  AddrWidth       = 56,
  parameter int unsigned  HostSourceWidth = 4,
  parameter int unsigned  SinkWidth       = 1,
  localparam int unsigned IdxWidth        = $clog2(NumHosts)
) (
  input logic              clk_i,
  input logic              rst_ni,
  tl_host_arbiter_if.slave host [NumHosts],
  tl_host_arbiter_if.master device
);
  typedef enum logic [1:0] {StIdle = 2'd0, StHold = 2'd1, StBurst = 2'd2} state_e;

  state_e                  state_q, state_d;
  logic [IdxWidth-1:0]     owner_q, owner_d, prio_q, prio_d, sel_idx, rr_idx, d_idx;
  logic [BeatCntWidth-1:0] beats_left_q, beats_left_d, sel_beats;
  logic                    sel_valid, rr_valid, a_hs, d_idx_ok;
  logic [NumHosts-1:0]     req, gnt, rr_gnt, d_hit, d_ready_vec, h_corrupt, host_unused;

  logic [2:0]                 h_opcode [NumHosts];
  logic [2:0]                 h_param  [NumHosts];
  logic [SizeWidth-1:0]       h_size   [NumHosts];
  logic [HostSourceWidth-1:0] h_source [NumHosts];
  logic [AddrWidth-1:0]       h_addr   [NumHosts];
  logic [DataWidth/8-1:0]     h_mask   [NumHosts];
  logic [DataWidth-1:0]       h_data   [NumHosts];
  logic [SinkWidth-1:0]       d_sink;
  logic                       unused_bce;

  function automatic logic [IdxWidth-1:0] next_idx(input logic [IdxWidth-1:0] i);
    return (32'(i) == NumHosts - 1) ? '0 : i + IdxWidth'(1);
  endfunction

  assign d_idx    = device.d_source[HostSourceWidth +: IdxWidth];
  assign d_idx_ok = 32'(d_idx) < NumHosts;
  assign d_sink   = device.d_sink;

  for (genvar i = 0; i < NumHosts; i++) begin : g_host
    assign req[i]         = host[i].a_valid;
    assign h_opcode[i]    = host[i].a_opcode;
    assign h_param[i]     = host[i].a_param;
    assign h_size[i]      = host[i].a_size;
    assign h_source[i]    = host[i].a_source;
    assign h_addr[i]      = host[i].a_address;
    assign h_mask[i]      = host[i].a_mask;
    assign h_data[i]      = host[i].a_data;
    assign h_corrupt[i]   = host[i].a_corrupt;
    assign host[i].a_ready = rst_ni & device.a_ready & gnt[i];

    assign d_hit[i]         = (d_idx == IdxWidth'(i));
    assign d_ready_vec[i]   = host[i].d_ready;
    assign host[i].d_valid  = rst_ni & device.d_valid & d_hit[i];
    assign host[i].d_opcode = device.d_opcode;
    assign host[i].d_param  = device.d_param;
    assign host[i].d_size   = device.d_size;
    assign host[i].d_source = device.d_source[HostSourceWidth-1:0];
    assign host[i].d_sink   = d_sink;
    assign host[i].d_denied = device.d_denied;
    assign host[i].d_data   = device.d_data;
    assign host[i].d_corrupt = device.d_corrupt;

    assign host[i].b_valid = 1'b0;
    assign host[i].c_ready = 1'b1;
    assign host[i].e_ready = 1'b1;
    assign host_unused[i]  = host[i].b_ready ^ host[i].c_valid ^ host[i].e_valid;
  end

  assign unused_bce = ^{device.b_valid, device.c_ready, device.e_ready, host_unused};

  tl_host_arbiter_rr_picker #(
    .NumReq(NumHosts)
  ) u_picker (
    .req  (req),
    .prio (prio_q),
    .gnt  (rr_gnt),
    .idx  (rr_idx),
    .valid(rr_valid)
  );

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    prio_d       = prio_q;
    beats_left_d = beats_left_q;
    gnt          = '0;
    sel_idx      = owner_q;
    sel_valid    = 1'b0;
    // Outside IDLE the grant stays with the owner even if its valid drops.
    if (state_q == StIdle) begin
      gnt       = rr_gnt;
      sel_idx   = rr_idx;
      sel_valid = rr_valid;
    end else begin
      gnt[owner_q] = 1'b1;
      sel_valid    = req[owner_q];
    end
    a_hs      = rst_ni & sel_valid & device.a_ready;
    sel_beats = BeatCntWidth'(tl_num_beats(tl_a_op_e'(h_opcode[sel_idx]), h_size[sel_idx],
                                           DataWidth));
    unique case (state_q)
      StIdle, StHold: begin
        if (a_hs) begin
          owner_d = sel_idx;
          if (sel_beats == BeatCntWidth'(1)) begin
            state_d = StIdle;
            prio_d  = next_idx(sel_idx);
          end else begin
            state_d      = StBurst;
            beats_left_d = sel_beats - BeatCntWidth'(1);
          end
        end else if (sel_valid) begin
          state_d = StHold;
          owner_d = sel_idx;
        end
      end
      StBurst: begin
        if (a_hs) begin
          beats_left_d = beats_left_q - BeatCntWidth'(1);
          if (beats_left_q == BeatCntWidth'(1)) begin
            state_d = StIdle;
            prio_d  = next_idx(owner_q);
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      owner_q      <= '0;
      prio_q       <= '0;
      beats_left_q <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      prio_q       <= prio_d;
      beats_left_q <= beats_left_d;
    end
  end

  assign device.a_valid   = rst_ni & sel_valid;
  assign device.a_opcode  = h_opcode[sel_idx];
  assign device.a_param   = h_param[sel_idx];
  assign device.a_size    = h_size[sel_idx];
  assign device.a_source  = {sel_idx, h_source[sel_idx]};
  assign device.a_address = h_addr[sel_idx];
  assign device.a_mask    = h_mask[sel_idx];
  assign device.a_data    = h_data[sel_idx];
  assign device.a_corrupt = h_corrupt[sel_idx];

  // A beat addressed to a non-existent host is swallowed so the device never stalls.
  assign device.d_ready = rst_ni & (d_idx_ok ? |(d_hit & d_ready_vec) : 1'b1);
  assign device.b_ready = 1'b1;
  assign device.c_valid = 1'b0;
  assign device.e_valid = 1'b0;

  a_d_index_in_range: assert property (@(posedge clk_i) disable iff (!rst_ni)
    device.d_valid |-> d_idx_ok)
    else $warning("tl_host_arbiter: D beat with out-of-range host index dropped");

  a_hold_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (state_q == StHold) |-> req[owner_q])
    else $warning("tl_host_arbiter: host dropped a_valid before its handshake");

endmodule

// File: tb/tb_tl_host_arbiter.sv
// Directed bench for tl_host_arbiter with three hosts (so index 3 is out of range).
// Expected device A beats go into a queue as stimulus is applied; a monitor pops and
// compares them on every device handshake.
module tb_tl_host_arbiter;
  import tl_host_arbiter_pkg::*;

  localparam int unsigned N = 3;

  logic clk, rst_n;
  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [5:0]  src;
    logic [63:0] data;
  } beat_t;
  beat_t exp_q[$];
  beat_t mon_e;

  logic [N-1:0] h_valid, h_d_ready, h_a_ready, h_d_valid;
  logic [2:0]   h_op     [N];
  logic [3:0]   h_size   [N];
  logic [3:0]   h_src    [N];
  logic [63:0]  h_data   [N];
  logic [3:0]   h_d_src  [N];
  logic [63:0]  h_d_data [N];

  tl_host_arbiter_if #(.DataWidth(64), .AddrWidth(56), .SourceWidth(4), .SinkWidth(1))
    host_if [N] ();
  tl_host_arbiter_if #(.DataWidth(64), .AddrWidth(56), .SourceWidth(6), .SinkWidth(1))
    dev_if ();

  for (genvar g = 0; g < N; g++) begin : g_hosts
    assign host_if[g].a_valid   = h_valid[g];
    assign host_if[g].a_opcode  = h_op[g];
    assign host_if[g].a_param   = 3'd0;
    assign host_if[g].a_size    = h_size[g];
    assign host_if[g].a_source  = h_src[g];
    assign host_if[g].a_address = h_data[g][55:0];
    assign host_if[g].a_mask    = 8'hff;
    assign host_if[g].a_data    = h_data[g];
    assign host_if[g].a_corrupt = 1'b0;
    assign host_if[g].d_ready   = h_d_ready[g];
    assign host_if[g].b_ready   = 1'b1;
    assign host_if[g].c_valid   = 1'b0;
    assign host_if[g].e_valid   = 1'b0;
    assign h_a_ready[g]         = host_if[g].a_ready;
    assign h_d_valid[g]         = host_if[g].d_valid;
    assign h_d_src[g]           = host_if[g].d_source;
    assign h_d_data[g]          = host_if[g].d_data;
  end

  tl_host_arbiter #(
    .NumHosts(N), .DataWidth(64), .AddrWidth(56), .HostSourceWidth(4), .SinkWidth(1)
  ) dut (
    .clk_i (clk),
    .rst_ni(rst_n),
    .host  (host_if),
    .device(dev_if)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic set_a(input int i, input logic v, input logic [2:0] op, input logic [3:0] sz,
                       input logic [3:0] src, input logic [63:0] data);
    h_valid[i] = v;
    h_op[i]    = op;
    h_size[i]  = sz;
    h_src[i]   = src;
    h_data[i]  = data;
  endtask

  task automatic push(input logic [1:0] idx, input logic [3:0] src, input logic [63:0] data);
    exp_q.push_back('{{idx, src}, data});
  endtask

  task automatic check_regs(input string tag, input logic [1:0] st, input logic [1:0] prio,
                            input logic [15:0] beats);
    check({tag, "_state"}, 64'(dut.state_q), 64'(st));
    check({tag, "_prio"}, 64'(dut.prio_q), 64'(prio));
    check({tag, "_beats"}, 64'(dut.beats_left_q), 64'(beats));
  endtask

  // Scoreboard: every device A handshake must match the next queued beat.
  always @(negedge clk) begin
    if (dev_if.a_valid && dev_if.a_ready) begin
      check("sb_expected_beat", 64'(exp_q.size() != 0), 64'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("sb_src", 64'(dev_if.a_source), 64'(mon_e.src));
        check("sb_data", dev_if.a_data, mon_e.data);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < N; i++) set_a(i, 1'b0, Get, 4'd3, 4'd0, 64'd0);
    h_d_ready = '0;
    dev_if.a_ready = 1'b0;
    dev_if.d_valid = 1'b0;  dev_if.d_opcode = 3'd1;  dev_if.d_param = 2'd0;
    dev_if.d_size  = 4'd3;  dev_if.d_source = 6'd0;  dev_if.d_sink  = 1'b0;
    dev_if.d_denied = 1'b0; dev_if.d_data   = 64'd0; dev_if.d_corrupt = 1'b0;
    dev_if.b_valid = 1'b0;  dev_if.c_ready  = 1'b1;  dev_if.e_ready = 1'b1;

    // Reset: outputs gated low and registers cleared.
    set_a(0, 1'b1, Get, 4'd3, 4'h1, 64'hA0);
    dev_if.a_ready = 1'b1;
    dev_if.d_valid = 1'b1;
    h_d_ready[0]   = 1'b1;
    step(); step();
    mid();
    check("rst_dev_a_valid", 64'(dev_if.a_valid), 64'd0);
    check("rst_h0_a_ready", 64'(h_a_ready[0]), 64'd0);
    check("rst_h0_d_valid", 64'(h_d_valid[0]), 64'd0);
    check("rst_dev_d_ready", 64'(dev_if.d_ready), 64'd0);
    check_regs("rst", 2'd0, 2'd0, 16'd0);
    check("rst_owner", 64'(dut.owner_q), 64'd0);
    set_a(0, 1'b0, Get, 4'd3, 4'h1, 64'hA0);
    dev_if.a_ready = 1'b0;
    dev_if.d_valid = 1'b0;
    step();
    rst_n = 1'b1;
    step();

    // Idle round-robin: grants alternate 0,1,0,1.
    set_a(0, 1'b1, Get, 4'd3, 4'h1, 64'h1000);
    set_a(1, 1'b1, Get, 4'd3, 4'h2, 64'h2000);
    for (int k = 0; k < 4; k++) begin
      if (k % 2 == 0) push(2'd0, 4'h1, 64'h1000);
      else            push(2'd1, 4'h2, 64'h2000);
    end
    dev_if.a_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      mid();
      check("rr_src_idx", 64'(dev_if.a_source[5:4]), 64'(k % 2));
      check("rr_h0_ready", 64'(h_a_ready[0]), 64'(k % 2 == 0));
      step();
    end
    h_valid[0] = 1'b0;
    h_valid[1] = 1'b0;
    check_regs("rr_end", 2'd0, 2'd2, 16'd0);

    // Burst lock: 4-beat PutFullData from host 0 holds off host 1.
    set_a(0, 1'b1, PutFullData, 4'd5, 4'h3, 64'hB0);
    set_a(1, 1'b1, Get, 4'd3, 4'h4, 64'hC1);
    for (int k = 0; k < 4; k++) push(2'd0, 4'h3, 64'hB0 + 64'(k));
    push(2'd1, 4'h4, 64'hC1);
    for (int k = 0; k < 4; k++) begin
      mid();
      check("burst_h0_ready", 64'(h_a_ready[0]), 64'd1);
      check("burst_h1_ready", 64'(h_a_ready[1]), 64'd0);
      step();
      check("burst_beats_left", 64'(dut.beats_left_q), 64'(3 - k));
      check("burst_state", 64'(dut.state_q), (k < 3) ? 64'd2 : 64'd0);
      h_data[0] = 64'hB0 + 64'(k + 1);
    end
    h_valid[0] = 1'b0;
    mid();
    check("burst_h1_after", 64'(h_a_ready[1]), 64'd1);
    step();
    h_valid[1] = 1'b0;
    check_regs("burst_end", 2'd0, 2'd2, 16'd0);

    // Stability: stalled host 1 keeps the device payload while host 0 arrives.
    dev_if.a_ready = 1'b0;
    set_a(1, 1'b1, Get, 4'd3, 4'h5, 64'hD1);
    for (int k = 0; k < 3; k++) begin
      mid();
      check("hold_src", 64'(dev_if.a_source), 64'h15);
      check("hold_data", dev_if.a_data, 64'hD1);
      step();
      check("hold_state", 64'(dut.state_q), 64'd1);
    end
    set_a(0, 1'b1, Get, 4'd3, 4'h6, 64'hD0);
    mid();
    check("hold_src_h0_valid", 64'(dev_if.a_source), 64'h15);
    check("hold_valid", 64'(dev_if.a_valid), 64'd1);
    step();
    push(2'd1, 4'h5, 64'hD1);
    push(2'd0, 4'h6, 64'hD0);
    dev_if.a_ready = 1'b1;
    mid();
    check("hold_h1_first", 64'(h_a_ready[1]), 64'd1);
    check("hold_h0_waits", 64'(h_a_ready[0]), 64'd0);
    step();
    h_valid[1] = 1'b0;
    mid();
    check("hold_h0_next", 64'(h_a_ready[0]), 64'd1);
    step();
    h_valid[0] = 1'b0;

    // D routing and backpressure.
    h_d_ready = 3'b011;
    dev_if.d_valid  = 1'b1;
    dev_if.d_source = 6'h17;
    dev_if.d_data   = 64'h5A5A;
    mid();
    check("d_h1_valid", 64'(h_d_valid), 64'b010);
    check("d_h1_src", 64'(h_d_src[1]), 64'h7);
    check("d_h1_data", h_d_data[1], 64'h5A5A);
    check("d_ready_h1", 64'(dev_if.d_ready), 64'd1);
    h_d_ready[1] = 1'b0;
    #1;
    check("d_bp_h1", 64'(dev_if.d_ready), 64'd0);
    dev_if.d_source = 6'h03;
    h_d_ready[0] = 1'b0;
    #1;
    check("d_h0_valid", 64'(h_d_valid), 64'b001);
    check("d_h0_src", 64'(h_d_src[0]), 64'h3);
    check("d_bp_h0", 64'(dev_if.d_ready), 64'd0);
    h_d_ready[0] = 1'b1;
    #1;
    check("d_ready_h0", 64'(dev_if.d_ready), 64'd1);
    step();

    // Out-of-range index: dropped with d_ready high and no host d_valid.
    h_d_ready = '0;
    dev_if.d_source = 6'h35;
    mid();
    check("bad_idx_d_ready", 64'(dev_if.d_ready), 64'd1);
    check("bad_idx_d_valid", 64'(h_d_valid), 64'd0);
    step();
    dev_if.d_valid = 1'b0;

    // Reset in the middle of a burst.
    set_a(0, 1'b1, PutFullData, 4'd5, 4'h8, 64'hE0);
    push(2'd0, 4'h8, 64'hE0);
    push(2'd0, 4'h8, 64'hE1);
    mid();
    check("rb_h0_ready", 64'(h_a_ready[0]), 64'd1);
    step();
    check("rb_beats1", 64'(dut.beats_left_q), 64'd3);
    h_data[0] = 64'hE1;
    mid();
    step();
    check("rb_beats2", 64'(dut.beats_left_q), 64'd2);
    set_a(1, 1'b1, Get, 4'd3, 4'h9, 64'hF1);
    rst_n = 1'b0;
    mid();
    check("rb_dev_a_valid", 64'(dev_if.a_valid), 64'd0);
    check("rb_a_ready", 64'(h_a_ready), 64'd0);
    step();
    check_regs("rb_rst", 2'd0, 2'd0, 16'd0);
    set_a(0, 1'b1, Get, 4'd3, 4'h8, 64'hE2);
    push(2'd0, 4'h8, 64'hE2);
    push(2'd1, 4'h9, 64'hF1);
    rst_n = 1'b1;
    mid();
    check("rb_first_grant", 64'(dev_if.a_source[5:4]), 64'd0);
    step();
    h_valid[0] = 1'b0;
    mid();
    check("rb_second_grant", 64'(dev_if.a_source[5:4]), 64'd1);
    step();
    h_valid[1] = 1'b0;

    for (int n = 0; n < 10 && exp_q.size() != 0; n++) step();
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
